// File: rtl/axi_lsu_bridge.sv
// rtl/axi_lsu_bridge.sv - single-outstanding load/store request bridge onto AXI3 single-beat reads and writes
module axi_lsu_bridge #(
    parameter logic [3:0] RD_ID = 4'h0,
    parameter logic [3:0] WR_ID = 4'h1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;

    state_t      state;
    logic        run;
    logic        aw_done;
    logic        w_done;
    logic        wen_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic [63:0] rdata_q;
    logic        aw_hs;
    logic        w_hs;
    logic        unused_ids;

    // Response IDs are never compared; one transaction is in flight at a time.
    assign unused_ids = ^{rid, bid};

    // run holds req_ready low until the first clock edge after reset releases.
    assign req_ready  = run && (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_rdata = wen_q ? 64'd0 : rdata_q;
    assign resp_err   = err_q;

    assign araddr  = addr_q;
    assign arid    = RD_ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'b011;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state == RD_ADDR);
    assign rready  = (state == RD_DATA);

    assign awaddr  = addr_q;
    assign awid    = WR_ID;
    assign awlen   = 8'd0;
    assign awsize  = 3'b011;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = (state == WR) && !aw_done;
    assign wid     = WR_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state == WR) && !w_done;
    assign bready  = (state == WR_RESP);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            run     <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 64'd0;
            wstrb_q <= 8'd0;
            rdata_q <= 64'd0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        wen_q   <= req_wen;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= req_wen ? WR : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (arready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rdata_q <= rdata;
                        err_q   <= (rresp != 2'b00) || !rlast;
                        state   <= DONE;
                    end
                end
                WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    // Both channels may complete in the same cycle.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WR_RESP;
                end
                WR_RESP: begin
                    if (bvalid) begin
                        err_q <= (bresp != 2'b00);
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
